color_cmd_decoder: RTL
======================

Name: color_cmd_decoder

Overview:
Byte-stream command decoder that produces the per-quadrant color updates consumed by the color processor. It takes received bytes from the serial front end and parses fixed 6-byte color frames. On a good frame it drives the updated 24-bit color on the matching rgbN output and pulses the matching color_valid bit for one cycle. Malformed, corrupted or stalled frames are dropped and flagged on frame_err.

Parameters:
HEADER, 8'hA5, frame start byte.
TIMEOUT, 50000, max idle clk cycles between bytes inside a frame; legal range >= 2.
CW, 16, timeout counter width; TIMEOUT must fit in CW bits.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
rx_data  input  8  received byte; valid only while rx_valid=1
rx_valid  input  1  single-cycle strobe, one per byte; may be high on consecutive cycles
color_valid  output  4  one-hot update strobe; bit n means rgbn carries a new color
rgb0, rgb1, rgb2, rgb3  output  24 each  color per channel, {R,G,B}, held between updates
frame_err  output  1  single-cycle pulse on any dropped frame
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (rst_n low, async): state=IDLE; rgb0..3=24'h0; color_valid=0; frame_err=0; busy=0; timeout counter=0; any partial frame is discarded.
- Frame format: HEADER, IDX, R, G, B, CHK. CHK = IDX ^ R ^ G ^ B.
- FSM states: IDLE, IDX, RED, GRN, BLU, CHK. A transition happens only on a cycle with rx_valid=1, except on timeout.
- IDLE: a byte equal to HEADER moves to IDX. Any other byte is discarded silently (no frame_err).
- IDX: if rx_data[7:2] != 0, pulse frame_err and go to IDLE. Otherwise latch idx=rx_data[1:0], set csum=rx_data, go to RED.
- RED, GRN, BLU: latch the byte and set csum ^= byte, then move to the next state.
- CHK: if rx_data == csum, load rgb[idx] with {R,G,B} and set color_valid[idx]=1. Otherwise pulse frame_err. Go to IDLE in both cases.
- HEADER bytes seen inside a frame are plain data; there is no mid-frame resync.
- Latency: color_valid, the rgbN update and frame_err are registered. All assert in the clock cycle after the rx_valid of the deciding byte.
- color_valid is high for exactly 1 cycle and is at most one-hot. The rgbN value changes in the same cycle as its strobe. Non-addressed rgb outputs never change.
- Timeout counter:
  - Held at 0 in IDLE.
  - Cleared on every accepted byte.
  - Increments each cycle without rx_valid in any other state.
  - When it reaches TIMEOUT-1 with rx_valid=0: pulse frame_err, go to IDLE, clear the counter.
  - If rx_valid arrives in the expiry cycle, the byte is processed and no timeout occurs.
- Back-to-back: a HEADER on the cycle right after CHK starts a new frame. The decoder sustains one byte per clock with no stalls.
- busy deasserts in the same cycle the FSM enters IDLE.

Test Plan:
- Frame A5 02 12 34 56 72 -> one cycle after the CHK byte: color_valid=4'b0100 for 1 cycle, rgb2=24'h123456; rgb0/1/3 remain 0; frame_err=0.
- Same frame with CHK=73 -> frame_err pulses 1 cycle; color_valid stays 0; rgb2 keeps its previous value; busy=0 afterwards.
- Frame A5 05 ... -> frame_err pulses the cycle after the IDX byte; FSM is back in IDLE; following bytes 11 22 33 are ignored; a next good frame for idx1 updates rgb1.
- Bytes A5 01 then rx_valid low for TIMEOUT cycles (TIMEOUT=8 in bench) -> frame_err pulses at expiry and busy falls. A byte arriving exactly at expiry instead keeps the frame alive (no frame_err).
- Garbage 00 FF 3C, then back-to-back frames A5 00 FF 00 00 FF and A5 03 00 00 FF FC with rx_valid every cycle -> color_valid=0001 then 0010 six cycles apart; rgb0=FF0000, rgb3=0000FF; no frame_err.
- rst_n pulled low after the RED byte of a frame -> all outputs 0 immediately (async). After release, the remaining bytes are ignored until a HEADER arrives; a following full frame updates correctly.

Source files
------------

// File: rtl/color_cmd_if.sv
// Byte-in / color-out bundle between the serial front end, the command
// decoder and the color processor.
interface color_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [3:0]  color_valid;
  logic [23:0] rgb0;
  logic [23:0] rgb1;
  logic [23:0] rgb2;
  logic [23:0] rgb3;
  logic        frame_err;
  logic        busy;

  modport master (
    output rx_data, rx_valid,
    input  color_valid, rgb0, rgb1, rgb2, rgb3, frame_err, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output color_valid, rgb0, rgb1, rgb2, rgb3, frame_err, busy
  );
endinterface

// File: rtl/color_cmd_decoder.sv
// Parses HEADER,IDX,R,G,B,CHK frames from a byte stream and emits one-cycle
// per-quadrant color updates; bad or stalled frames are dropped on frame_err.
module color_cmd_decoder #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         TIMEOUT = 50000,
  parameter int         CW      = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  color_cmd_if.slave  bus
);

  localparam int NUM_CH = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_IDX, S_RED, S_GRN, S_BLU, S_CHK
  } state_t;

  state_t                        r_state, w_nxt;
  logic [1:0]                    r_idx;
  logic [7:0]                    r_red, r_grn, r_blu, r_csum;
  logic [CW-1:0]                 r_cnt;
  logic [NUM_CH-1:0][23:0]       r_rgb;
  logic [NUM_CH-1:0]             r_cv;
  logic                          r_err;

  logic w_tmo, w_err, w_upd, w_busy, w_idx_bad;

  // Expiry only when no byte shows up; a byte in the expiry cycle wins.
  assign w_tmo     = (r_state != S_IDLE) && !bus.rx_valid &&
                     (r_cnt == CW'(TIMEOUT - 1));
  assign w_idx_bad = (bus.rx_data[7:2] != 6'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (bus.rx_valid) begin
      case (r_state)
        S_IDLE:  if (bus.rx_data == HEADER) w_nxt = S_IDX;
        S_IDX:   w_nxt = w_idx_bad ? S_IDLE : S_RED;
        S_RED:   w_nxt = S_GRN;
        S_GRN:   w_nxt = S_BLU;
        S_BLU:   w_nxt = S_CHK;
        S_CHK:   w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end else if (w_tmo) begin
      w_nxt = S_IDLE;
    end
  end

  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_upd  = 1'b0;
    w_err  = w_tmo;
    if (bus.rx_valid) begin
      if (r_state == S_IDX && w_idx_bad) w_err = 1'b1;
      if (r_state == S_CHK) begin
        if (bus.rx_data == r_csum) w_upd = 1'b1;
        else                       w_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_red  <= '0;
      r_grn  <= '0;
      r_blu  <= '0;
      r_csum <= '0;
      r_cnt  <= '0;
      r_rgb  <= '0;
      r_cv   <= '0;
      r_err  <= 1'b0;
    end else begin
      r_cv  <= w_upd ? NUM_CH'(1) << r_idx : '0;
      r_err <= w_err;
      r_cnt <= (r_state == S_IDLE || bus.rx_valid || w_tmo) ? '0 : r_cnt + 1'b1;
      for (int n = 0; n < NUM_CH; n++)
        if (w_upd && r_idx == 2'(n)) r_rgb[n] <= {r_red, r_grn, r_blu};
      if (bus.rx_valid) begin
        case (r_state)
          S_IDX: begin
            r_idx  <= bus.rx_data[1:0];
            r_csum <= bus.rx_data;
          end
          S_RED: begin
            r_red  <= bus.rx_data;
            r_csum <= r_csum ^ bus.rx_data;
          end
          S_GRN: begin
            r_grn  <= bus.rx_data;
            r_csum <= r_csum ^ bus.rx_data;
          end
          S_BLU: begin
            r_blu  <= bus.rx_data;
            r_csum <= r_csum ^ bus.rx_data;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.color_valid = r_cv;
  assign bus.rgb0        = r_rgb[0];
  assign bus.rgb1        = r_rgb[1];
  assign bus.rgb2        = r_rgb[2];
  assign bus.rgb3        = r_rgb[3];
  assign bus.frame_err   = r_err;
  assign bus.busy        = w_busy;

endmodule
